// File: rtl/ecc_encode_pipe.sv
// SECDED (39,32) write-side encoder with valid/ready on both sides and a 1-entry skid buffer.
// Optional error injection on the codeword path is enabled by defining ECC_ERR_INJ_EN.
module ecc_encode_pipe #(
  parameter int P_DATAWIDTH = 32,
  parameter int P_CODEWIDTH = 39,
  parameter int P_CNTWIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [P_DATAWIDTH-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_CODEWIDTH-1:0] code_out,
  output logic [P_CNTWIDTH-1:0]  word_cnt
`ifdef ECC_ERR_INJ_EN
  ,
  input  logic                   inj_valid,
  input  logic [P_CODEWIDTH-1:0] inj_mask,
  output logic                   inj_pending
`endif
);

  // Check bit k is bit k of the XOR of (j+1) over all set data positions j.
  function automatic logic [38:0] secded_encode(input logic [31:0] d);
    logic [38:0] c;
    logic [5:0]  p;
    c = {1'b0, d[31:26], 1'b0, d[25:11], 1'b0, d[10:4], 1'b0, d[3:1], 1'b0, d[0], 1'b0, 1'b0};
    p = '0;
    for (logic [5:0] j = 6'd0; j < 6'd38; j = j + 6'd1) begin
      if (c[j]) p = p ^ (j + 6'd1);
    end
    c[0]  = p[0];
    c[1]  = p[1];
    c[3]  = p[2];
    c[7]  = p[3];
    c[15] = p[4];
    c[31] = p[5];
    c[38] = ^c[37:0];
    return c;
  endfunction

  logic                   out_valid_q, out_valid_d;
  logic [P_CODEWIDTH-1:0] code_q, code_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [P_CODEWIDTH-1:0] skid_q, skid_d;
  logic                   in_ready_q, in_ready_d;
  logic [P_CNTWIDTH-1:0]  cnt_q, cnt_d;
  logic                   accept, take;
  logic [P_CODEWIDTH-1:0] enc;

`ifdef ECC_ERR_INJ_EN
  logic                   armed_q, armed_d;
  logic [P_CODEWIDTH-1:0] mask_q, mask_d;
  logic [P_CODEWIDTH-1:0] eff_mask;

  // A pulse coincident with an acceptance applies to that very word.
  always_comb begin
    eff_mask = '0;
    armed_d  = armed_q;
    mask_d   = mask_q;
    if (inj_valid)    eff_mask = inj_mask;
    else if (armed_q) eff_mask = mask_q;
    if (accept) begin
      armed_d = 1'b0;
      mask_d  = '0;
    end else if (inj_valid) begin
      armed_d = 1'b1;
      mask_d  = inj_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed_q <= 1'b0;
    else     armed_q <= armed_d;
  end

  always_ff @(posedge clk) begin
    mask_q <= mask_d;
  end

  assign enc         = secded_encode(data_in) ^ eff_mask;
  assign inj_pending = armed_q;
`else
  assign enc = secded_encode(data_in);
`endif

  assign accept = in_valid && in_ready_q;
  assign take   = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    code_d       = code_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    cnt_d        = cnt_q;
    if (!out_valid_q || take) begin
      // Skid is always older than anything arriving now; in_ready is low while it is full.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        code_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        code_d      = enc;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = enc;
    end
    in_ready_d = !skid_valid_d;
    if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      code_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      code_q       <= code_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign code_out  = code_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_ecc_encode_pipe.sv
// Scoreboard bench for ecc_encode_pipe: reference encoder/decoder, stall, reset and injection scenarios.
module tb_ecc_encode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [38:0] code_out;
  logic [15:0] word_cnt;
  logic        inj_valid;
  logic [38:0] inj_mask;
  logic        inj_pending;

  ecc_encode_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code_out  (code_out),
    .word_cnt  (word_cnt)
`ifdef ECC_ERR_INJ_EN
    ,
    .inj_valid   (inj_valid),
    .inj_mask    (inj_mask),
    .inj_pending (inj_pending)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [38:0] code;
    logic [31:0] data;
    logic        se;
    logic        de;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] cnt_model;
  logic        held;
  logic [38:0] held_code;
  logic        acc_last;
  logic [38:0] cur_mask;
  logic        cur_se;
  logic        cur_de;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_check_pos(input int j);
    return (((j + 1) & j) == 0);
  endfunction

  // Reference encoder written straight from the layout: per check bit, XOR the covered data positions.
  function automatic logic [38:0] model_encode(input logic [31:0] d);
    logic [38:0] c;
    logic        p;
    int          di;
    c  = '0;
    di = 0;
    for (int j = 0; j < 38; j++) begin
      if (!is_check_pos(j)) begin
        c[j] = d[di];
        di++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      p = 1'b0;
      for (int j = 0; j < 38; j++)
        if (!is_check_pos(j) && (((j + 1) >> k) & 1) == 1) p = p ^ c[j];
      c[(1 << k) - 1] = p;
    end
    c[38] = ^c[37:0];
    return c;
  endfunction

  task automatic model_decode(input logic [38:0] cw, output logic [31:0] d,
                              output logic se, output logic de);
    logic [38:0] c;
    int          syn;
    int          di;
    logic        par;
    c   = cw;
    syn = 0;
    for (int j = 0; j < 38; j++) if (c[j]) syn = syn ^ (j + 1);
    par = ^c;
    se  = 1'b0;
    de  = 1'b0;
    if (par) begin
      se = 1'b1;
      if (syn != 0 && syn <= 38) c[syn - 1] = ~c[syn - 1];
    end else if (syn != 0) begin
      de = 1'b1;
    end
    d  = '0;
    di = 0;
    for (int j = 0; j < 38; j++) begin
      if (!is_check_pos(j)) begin
        d[di] = c[j];
        di++;
      end
    end
  endtask

  task automatic cycle();
    exp_t        e;
    logic [31:0] dd;
    logic        se, de;
    @(negedge clk);
    acc_last = in_valid && in_ready;
    if (held) chk("hold_stable", code_out, held_code);
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("codeword", code_out, e.code);
        model_decode(code_out, dd, se, de);
        chk("dec_single", se, e.se);
        chk("dec_double", de, e.de);
        if (!e.de) chk("dec_data", dd, e.data);
      end
    end
    held      = out_valid && !out_ready;
    held_code = code_out;
    if (acc_last) begin
      e.code = model_encode(data_in) ^ cur_mask;
      e.data = data_in;
      e.se   = cur_se;
      e.de   = cur_de;
      sbq.push_back(e);
      cnt_model++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input logic [31:0] d, input logic [38:0] exp_code, input string tag);
    in_valid  = 1'b1;
    data_in   = d;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk({tag, "_accepted"}, acc_last, 1);
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, code_out, exp_code);
    cycle();
  endtask

  logic [31:0] words[4];
  int          idx;
  int          sent;
  int          cyc;
  logic [15:0] base;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    inj_valid = 1'b0;
    inj_mask  = '0;
    cnt_model = '0;
    held      = 1'b0;
    held_code = '0;
    acc_last  = 1'b0;
    cur_mask  = '0;
    cur_se    = 1'b0;
    cur_de    = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_code_out", code_out, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_check(32'h00000000, 39'h0000000000, "enc_zero");
    chk("cnt_after_one", word_cnt, 1);
    send_check(32'h00000001, 39'h4000000007, "enc_one");
    send_check(32'hFFFFFFFF, 39'h3F7FFFFFF4, "enc_ones");
    chk("idle_out_valid", out_valid, 0);

    words[0] = 32'h12345678;
    words[1] = 32'h9ABCDEF0;
    words[2] = 32'h0F0F0F0F;
    words[3] = 32'hA5A5A5A5;
    base = word_cnt;
    idx  = 0;
    for (int c = 1; c <= 14; c++) begin
      out_ready = (c < 2 || c > 5);
      if (idx < 4) begin
        in_valid = 1'b1;
        data_in  = words[idx];
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (acc_last) begin
        idx++;
        if (idx == 2) chk("in_ready_drop", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    chk("stream_cnt", word_cnt - base, 4);
    chk("stream_drained", sbq.size(), 0);

    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || sbq.size() != 0) && cyc < 60000) begin
      if (acc_last) sent++;
      if (!in_valid || acc_last) begin
        in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        data_in  = $urandom;
      end
      out_ready = $urandom_range(0, 1) == 1;
      cycle();
      cyc++;
    end
    if (acc_last) sent++;
    in_valid = 1'b0;
    chk("random_complete", (sent == 10000) && (sbq.size() == 0), 1);
    chk("random_cnt", word_cnt, cnt_model);

    out_ready = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 2 && cyc < 20) begin
      in_valid = 1'b1;
      data_in  = $urandom;
      cycle();
      if (acc_last) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_skid_full", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_word_cnt", word_cnt, 0);
    chk("midrst_code_out", code_out, 0);
    rst = 1'b0;
    sbq.delete();
    cnt_model = '0;
    held      = 1'b0;
    @(posedge clk);
    #1;
    send_check(32'h00000001, 39'h4000000007, "post_rst_enc");
    chk("post_rst_cnt", word_cnt, 1);

`ifdef ECC_ERR_INJ_EN
    chk("inj_idle", inj_pending, 0);
    inj_valid = 1'b1;
    inj_mask  = 39'h0000000004;
    cycle();
    inj_valid = 1'b0;
    chk("inj_armed", inj_pending, 1);
    cur_mask = 39'h0000000004;
    cur_se   = 1'b1;
    send_check(32'h00000000, 39'h0000000004, "inj_single");
    chk("inj_cleared", inj_pending, 0);
    cur_mask  = 39'h0000000006;
    cur_se    = 1'b0;
    cur_de    = 1'b1;
    inj_valid = 1'b1;
    inj_mask  = 39'h0000000006;
    in_valid  = 1'b1;
    data_in   = 32'h0;
    out_ready = 1'b1;
    cycle();
    inj_valid = 1'b0;
    in_valid  = 1'b0;
    chk("inj_same_cycle", code_out, 39'h0000000006);
    chk("inj_same_cleared", inj_pending, 0);
    cycle();
    cur_mask = '0;
    cur_de   = 1'b0;
    send_check(32'h00000000, 39'h0000000000, "inj_not_sticky");
`endif

    chk("final_cnt", word_cnt, cnt_model);
    chk("final_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_encode_pipe.md
Name: ecc_encode_pipe

Overview:
- Write-side SECDED encoder for FPGA RAM models: 32-bit data in, 39-bit Hamming+overall-parity codeword out.
- Sits in front of the RAM write port. Its codewords are decodable by the team's 39/32 SECDED decoder with no error flags raised.
- Registered, with valid/ready handshakes on both sides and a 1-entry skid buffer so that in_ready is a registered signal.
- Keeps a running count of encoded words.

Parameters:
- P_DATAWIDTH, 32, data width. Fixed; other values are unsupported.
- P_CODEWIDTH, 39, codeword width.
- P_CNTWIDTH, 16, width of the encoded-word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block can accept a word. Registered.
- data_in  in  32  data to encode.
- out_valid  out  1  code_out is valid.
- out_ready  in  1  downstream accepts code_out.
- code_out  out  39  encoded word.
- word_cnt  out  P_CNTWIDTH  number of words accepted at the input.

Behaviour:
- Reset (async assert, sync release): out_valid=0, code_out=0, in_ready=1, word_cnt=0, skid buffer empty.
- Codeword layout (index j=0..38):
  - Check bits at j = 0, 1, 3, 7, 15, 31.
  - Data bits fill the remaining j=0..37 in ascending order: data[0]→c[2], data[1..3]→c[4..6], data[4..10]→c[8..14], data[11..25]→c[16..30], data[26..31]→c[32..37].
- Check bit c[2^k−1], k=0..5 = XOR of every data position j≤37 with bit k of (j+1) set.
- c[38] = XOR of c[0..37], i.e. even overall parity.
- Input handshake: a word is accepted when in_valid && in_ready.
- Latency: an accepted word is presented on code_out on the next cycle, provided the output register was empty or drained that cycle.
- Output register holds code_out stable while out_valid && !out_ready.
- Skid buffer:
  - Input accepted while the output register holds an un-taken word → encoded word goes to the skid buffer; in_ready drops the next cycle.
  - When the output register is taken and the skid buffer is full → skid contents move into the output register next cycle; in_ready rises the next cycle.
  - Output taken and new input accepted in the same cycle, skid empty → output register loads the new codeword; out_valid stays 1.
- Order is strictly preserved; no word is dropped or duplicated.
- in_valid when in_ready=0: ignored. Upstream holds the data.
- word_cnt increments by 1 per accepted word and wraps 2^P_CNTWIDTH−1 → 0.
- Reset mid-operation: held words are discarded and all outputs return to their reset values immediately.

Optional Feature:
- Macro ECC_ERR_INJ_EN.
- Defined:
  - Extra ports inj_valid (in, 1) and inj_mask (in, 39).
  - inj_valid pulse arms a 39-bit mask register. A new pulse before consumption overwrites the mask.
  - The next accepted word has code_out = codeword XOR mask; the mask then clears.
  - inj_valid in the same cycle as an acceptance applies to that word.
  - Extra output inj_pending (1) is high while a mask is armed. Reset: disarmed.
- Undefined: none of these ports exist; codewords are never modified.

Test Plan:
- Encode 32'h00000000, out_ready=1 → code_out=39'h0000000000 one cycle after accept; word_cnt=1.
- Encode 32'h00000001 → code_out=39'h4000000007.
- Encode 32'hFFFFFFFF → code_out=39'h3F7FFFFFF4.
- Stream 4 words, out_ready=0 for cycles 2-5:
  - in_ready drops after the second word is accepted.
  - Words emerge in order once out_ready=1, held stable while stalled.
  - word_cnt=4.
- Random 10k words through the SECDED decoder with out_ready toggled randomly → data matches, single_error=0, double_error=0.
- Assert rst while out_valid=1 and skid full → out_valid=0, in_ready=1, word_cnt=0 without a clock edge.
- With ECC_ERR_INJ_EN:
  - inj_mask=39'h0000000004 on data 32'h0 → decoder gives data 32'h0, single_error=1.
  - Mask 39'h0000000006 → double_error=1.
